// File: rtl/fft_stream_ctrl.sv
// FIFO-to-FFT stream sequencer: drains a 1-cycle-latency sample FIFO through a 2-entry
// skid buffer into a ready/valid FFT sink, with core reset, framing, channel tag and zero-pad.
module fft_stream_ctrl #(
   parameter int DATA_W      = 32,
   parameter int FFT_LEN     = 128,
   parameter int CNT_W       = 8,
   parameter int RST_CYCLES  = 31,
   parameter int NUM_CH      = 1,
   parameter int CH_W        = 1,
   parameter int PAD_TIMEOUT = 16
) (
   input  logic              clk_100m,
   input  logic              rst_n,
   input  logic              restart,
   input  logic              pad_en,
   input  logic              fifo_rd_empty,
   input  logic [DATA_W-1:0] fifo_q,
   output logic              fifo_rdreq,
   input  logic              fft_ready,
   output logic              fft_rst_n,
   output logic              fft_valid,
   output logic [DATA_W-1:0] fft_data,
   output logic              fft_sop,
   output logic              fft_eop,
   output logic [CH_W-1:0]   ch_idx,
   output logic [15:0]       frame_cnt,
   output logic              padded
);

   localparam int RST_W    = $clog2(RST_CYCLES + 1);
   localparam int STARVE_W = $clog2(PAD_TIMEOUT + 1);
   localparam logic [CNT_W-1:0]    LAST_IDX    = CNT_W'(FFT_LEN - 1);
   localparam logic [CH_W-1:0]     LAST_CH     = CH_W'(NUM_CH - 1);
   localparam logic [RST_W-1:0]    RST_LAST    = RST_W'(RST_CYCLES - 1);
   localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(PAD_TIMEOUT - 1);

   typedef enum logic [1:0] {S_RST, S_WAIT, S_RUN} state_t;

   state_t              state;
   logic [RST_W-1:0]    rst_cnt;
   logic [1:0]          occ;
   logic                rd_pend;
   logic [CNT_W-1:0]    idx;
   logic [STARVE_W-1:0] starve_cnt;
   logic                padding;
   logic [DATA_W-1:0]   buf0;
   logic [DATA_W-1:0]   buf1;

   logic       accept;
   logic       buf_pop;
   logic       at_last;
   logic       starving;
   logic [2:0] credit_used;

   assign fft_valid = (occ != 2'd0) | padding;
   assign fft_data  = (occ != 2'd0) ? buf0 : '0;
   assign accept    = fft_valid & fft_ready;
   assign buf_pop   = accept & (occ != 2'd0);
   assign at_last   = (idx == LAST_IDX);
   assign fft_sop   = fft_valid & (idx == '0);
   assign fft_eop   = fft_valid & at_last;
   assign padded    = accept & padding & at_last;

   // A word leaving the head this cycle frees its slot for a read issued now, which is what
   // sustains one sample per cycle with only two entries.
   assign credit_used = 3'(occ) + 3'(rd_pend) - 3'(buf_pop);
   assign fifo_rdreq  = (state == S_RUN) & ~fifo_rd_empty & ~padding & (credit_used < 3'd2);

   assign starving = pad_en & (state == S_RUN) & (idx != '0) & (occ == 2'd0) & ~rd_pend &
                     ~fifo_rdreq & ~padding;

   // NOTE: all state updates use non-blocking assignments so every register sees the
   // pre-edge values of its peers, independent of statement order.
   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_RST;
         rst_cnt    <= '0;
         fft_rst_n  <= 1'b0;
         occ        <= 2'd0;
         rd_pend    <= 1'b0;
         idx        <= '0;
         starve_cnt <= '0;
         padding    <= 1'b0;
         ch_idx     <= '0;
         frame_cnt  <= 16'd0;
      end else if (restart) begin
         state      <= S_RST;
         rst_cnt    <= '0;
         fft_rst_n  <= 1'b0;
         occ        <= 2'd0;
         rd_pend    <= 1'b0;
         idx        <= '0;
         starve_cnt <= '0;
         padding    <= 1'b0;
      end else begin
         rd_pend <= fifo_rdreq;
         occ     <= occ + {1'b0, rd_pend} - {1'b0, buf_pop};

         case (state)
            S_RST: begin
               if (rst_cnt == RST_LAST) begin
                  fft_rst_n <= 1'b1;
                  rst_cnt   <= '0;
                  state     <= S_WAIT;
               end else begin
                  rst_cnt <= rst_cnt + 1'b1;
               end
            end
            S_WAIT:  if (fft_ready) state <= S_RUN;
            S_RUN:   state <= S_RUN;
            default: state <= S_RST;
         endcase

         if (accept) begin
            starve_cnt <= '0;
            if (at_last) begin
               idx       <= '0;
               ch_idx    <= (ch_idx == LAST_CH) ? '0 : ch_idx + 1'b1;
               frame_cnt <= frame_cnt + 16'd1;
               padding   <= 1'b0;
            end else begin
               idx <= idx + 1'b1;
            end
         end else if (starving) begin
            if (starve_cnt == STARVE_LAST) begin
               padding    <= 1'b1;
               starve_cnt <= '0;
            end else begin
               starve_cnt <= starve_cnt + 1'b1;
            end
         end else if (!pad_en) begin
            starve_cnt <= '0;
         end
      end
   end

   // NOTE: skid data registers have no reset; occ qualifies them, so a stale or
   // discarded word is never presented.
   always_ff @(posedge clk_100m) begin
      if (rd_pend) begin
         if (occ == 2'd0 || (occ == 2'd1 && buf_pop)) begin
            buf0 <= fifo_q;
         end else if (buf_pop) begin
            buf0 <= buf1;
            buf1 <= fifo_q;
         end else begin
            buf1 <= fifo_q;
         end
      end else if (buf_pop) begin
         buf0 <= buf1;
      end
   end

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Scoreboard bench for fft_stream_ctrl: stimulus pushes expected samples into a queue,
// a negedge monitor pops and compares every accepted word.
module tb_fft_stream_ctrl;

   localparam int DATA_W = 32;
   localparam int FFT_LEN = 128;
   localparam int NUM_CH = 3;
   localparam int CH_W = 2;

   logic              clk_100m = 1'b0;
   logic              rst_n;
   logic              restart;
   logic              pad_en;
   logic              fifo_rd_empty;
   logic [DATA_W-1:0] fifo_q = '0;
   logic              fifo_rdreq;
   logic              fft_ready;
   logic              fft_rst_n;
   logic              fft_valid;
   logic [DATA_W-1:0] fft_data;
   logic              fft_sop;
   logic              fft_eop;
   logic [CH_W-1:0]   ch_idx;
   logic [15:0]       frame_cnt;
   logic              padded;

   always #5 clk_100m = ~clk_100m;

   fft_stream_ctrl #(
      .DATA_W(DATA_W), .FFT_LEN(FFT_LEN), .CNT_W(8), .RST_CYCLES(31),
      .NUM_CH(NUM_CH), .CH_W(CH_W), .PAD_TIMEOUT(16)
   ) dut (
      .clk_100m(clk_100m), .rst_n(rst_n), .restart(restart), .pad_en(pad_en),
      .fifo_rd_empty(fifo_rd_empty), .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq),
      .fft_ready(fft_ready), .fft_rst_n(fft_rst_n), .fft_valid(fft_valid),
      .fft_data(fft_data), .fft_sop(fft_sop), .fft_eop(fft_eop), .ch_idx(ch_idx),
      .frame_cnt(frame_cnt), .padded(padded)
   );

   // FIFO model: array and write pointer owned by stimulus, read pointer by the read port.
   logic [DATA_W-1:0] fifo_mem [0:2047];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign fifo_rd_empty = (rd_ptr == wr_ptr);

   always @(posedge clk_100m) begin
      if (fifo_rdreq && rd_ptr != wr_ptr) begin
         fifo_q <= fifo_mem[rd_ptr];
         rd_ptr <= rd_ptr + 1;
      end
   end

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              sop;
      logic              eop;
      logic [CH_W-1:0]   ch;
      logic [15:0]       fcnt;
      logic              pad;
      int                gap;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: compares every handshake against the scoreboard and checks stall stability.
   int          gap = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data = '0;

   always @(negedge clk_100m) begin
      if (rst_n) begin
         if (prev_stall) begin
            check("stall_valid", 32'(fft_valid), 32'd1);
            check("stall_data", fft_data, prev_data);
         end
         if (fifo_rdreq) check("rdreq_while_empty", 32'(fifo_rd_empty), 32'd0);
         if (fft_valid && fft_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got 0x%0h, nothing expected at %0t", fft_data, $time);
            end else begin
               mon_e = exp_q.pop_front();
               check("data", fft_data, mon_e.data);
               check("sop", 32'(fft_sop), 32'(mon_e.sop));
               check("eop", 32'(fft_eop), 32'(mon_e.eop));
               check("ch_idx", 32'(ch_idx), 32'(mon_e.ch));
               check("frame_cnt", 32'(frame_cnt), 32'(mon_e.fcnt));
               check("padded", 32'(padded), 32'(mon_e.pad));
               if (mon_e.gap >= 0) check("pad_gap", gap, mon_e.gap);
            end
            gap = 0;
         end else if (!fft_valid) begin
            gap++;
         end
         prev_stall = fft_valid && !fft_ready;
         prev_data  = fft_data;
      end
   end

   // Stimulus-side framing model.
   int s_idx = 0;
   int s_ch = 0;
   int s_frames = 0;

   task automatic push_exp(input logic [31:0] d, input logic pad, input int g);
      exp_t e;
      e.data = d;
      e.sop  = (s_idx == 0);
      e.eop  = (s_idx == FFT_LEN - 1);
      e.ch   = CH_W'(s_ch);
      e.fcnt = 16'(s_frames);
      e.pad  = pad && e.eop;
      e.gap  = g;
      exp_q.push_back(e);
      if (s_idx == FFT_LEN - 1) begin
         s_idx = 0;
         s_ch = (s_ch == NUM_CH - 1) ? 0 : s_ch + 1;
         s_frames++;
      end else begin
         s_idx++;
      end
   endtask

   task automatic push_word(input logic [31:0] d);
      fifo_mem[wr_ptr] = d;
      wr_ptr++;
      push_exp(d, 1'b0, -1);
   endtask

   task automatic tick();
      @(posedge clk_100m);
      #1;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check(name, exp_q.size(), 32'd0);
   endtask

   task automatic count_rst_low(input string name);
      int n = 0;
      while (!fft_rst_n && n < 100) begin
         n++;
         tick();
      end
      check(name, n, 32'd31);
   endtask

   initial begin
      int n;
      int v;
      rst_n = 1'b0;
      restart = 1'b0;
      pad_en = 1'b0;
      fft_ready = 1'b0;
      repeat (3) tick();

      // T1: reset values, core reset length, no reads before the sink is ready
      check("rst_fft_rst_n", 32'(fft_rst_n), 32'd0);
      check("rst_valid", 32'(fft_valid), 32'd0);
      check("rst_rdreq", 32'(fifo_rdreq), 32'd0);
      check("rst_data", fft_data, 32'd0);
      check("rst_sop", 32'(fft_sop), 32'd0);
      check("rst_eop", 32'(fft_eop), 32'd0);
      check("rst_ch_idx", 32'(ch_idx), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check("rst_padded", 32'(padded), 32'd0);
      for (int i = 0; i < 256; i++) push_word(32'h1000_0000 + i);
      rst_n = 1'b1;
      count_rst_low("t1_rst_low_cycles");
      for (int i = 0; i < 10; i++) begin
         check("t1_no_rdreq_before_ready", 32'(fifo_rdreq), 32'd0);
         tick();
      end

      // T2: two back-to-back frames
      fft_ready = 1'b1;
      n = 0;
      while (!fft_valid && n < 20) begin
         tick();
         n++;
      end
      check("t2_first_valid", 32'(fft_valid), 32'd1);
      v = 0;
      for (int i = 0; i < 256; i++) begin
         if (fft_valid) v++;
         tick();
      end
      check("t2_back_to_back", v, 32'd256);
      check("t2_idle_after", 32'(fft_valid), 32'd0);
      wait_drain("t2_drain", 50);
      check("t2_frame_cnt", 32'(frame_cnt), 32'd2);
      check("t2_ch_idx", 32'(ch_idx), 32'd2);

      // T3: random backpressure over three frames
      for (int i = 0; i < 384; i++) push_word(32'h2000_0000 + i);
      n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         fft_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      fft_ready = 1'b1;
      check("t3_drain", exp_q.size(), 32'd0);
      check("t3_frame_cnt", 32'(frame_cnt), 32'd5);

      // T4a: starved frame closed with 28 zeros after 16 idle cycles
      pad_en = 1'b1;
      for (int i = 0; i < 100; i++) push_word(32'h3000_0000 + i);
      push_exp(32'd0, 1'b1, 16);
      for (int i = 0; i < 27; i++) push_exp(32'd0, 1'b1, -1);
      wait_drain("t4_pad_drain", 600);
      tick();
      check("t4_pad_frame_cnt", 32'(frame_cnt), 32'd6);
      check("t4_padded_pulse_end", 32'(padded), 32'd0);

      // T4b: padding disabled, frame stalls until data returns
      pad_en = 1'b0;
      for (int i = 0; i < 100; i++) push_word(32'h4000_0000 + i);
      wait_drain("t4_nopad_drain", 600);
      v = 0;
      for (int i = 0; i < 60; i++) begin
         if (fft_valid) v++;
         tick();
      end
      check("t4_stall_no_valid", v, 32'd0);
      check("t4_stall_frame_cnt", 32'(frame_cnt), 32'd6);
      for (int i = 0; i < 28; i++) push_word(32'h4100_0000 + i);
      wait_drain("t4_resume_drain", 200);
      tick();
      check("t4_resume_frame_cnt", 32'(frame_cnt), 32'd7);

      // T6: restart at sample 50 with a read in flight
      for (int i = 0; i < 50; i++) push_word(32'h5000_0000 + i);
      wait_drain("t6_partial_drain", 200);
      repeat (5) tick();
      fifo_mem[wr_ptr] = 32'hDEAD_BEEF;
      wr_ptr++;
      tick();
      check("t6_read_in_flight", rd_ptr, wr_ptr);
      restart = 1'b1;
      tick();
      restart = 1'b0;
      s_idx = 0;
      check("t6_valid_after_restart", 32'(fft_valid), 32'd0);
      check("t6_frame_cnt_kept", 32'(frame_cnt), 32'd7);
      check("t6_ch_idx_kept", 32'(ch_idx), 32'd1);
      count_rst_low("t6_rst_low_cycles");
      for (int i = 0; i < 128; i++) push_word(32'h6000_0000 + i);
      wait_drain("t6_frame_drain", 600);
      tick();
      check("t6_frame_cnt", 32'(frame_cnt), 32'd8);
      check("t6_ch_idx", 32'(ch_idx), 32'd2);
      repeat (5) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
